// File: rtl/uart_alu_if.sv
// uart_alu_if: collects an operand/operand/opcode byte triple from a UART
// receiver, drives a combinational ALU, and sends the one-byte result back
// through the UART transmitter.
// Optional feature: define UART_ALU_IF_TIMEOUT_EN to add an inter-byte
// timeout in S_B/S_OP that abandons a partial command after TIMEOUT_CYCLES.
module uart_alu_if #(
    parameter int DATA_BITS      = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_ferr,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    output logic [DATA_BITS-1:0] alu_a,
    output logic [DATA_BITS-1:0] alu_b,
    output logic [OP_BITS-1:0]   alu_op,
    input  logic [DATA_BITS-1:0] alu_result,
    output logic                 busy,
    output logic                 err_drop
);

    typedef enum logic [2:0] {
        S_A       = 3'd0,
        S_B       = 3'd1,
        S_OP      = 3'd2,
        S_LATCH   = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_HI = 3'd5,
        S_WAIT_LO = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_rx_phase;
    logic                   w_drop;
    logic                   w_timeout;

    logic                   r_tx_start;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic [DATA_BITS-1:0]   r_alu_a;
    logic [DATA_BITS-1:0]   r_alu_b;
    logic [OP_BITS-1:0]     r_alu_op;
    logic                   r_busy;
    logic                   r_err_drop;

    logic                   w_tx_start_nxt;
    logic [DATA_BITS-1:0]   w_tx_data_nxt;
    logic [DATA_BITS-1:0]   w_alu_a_nxt;
    logic [DATA_BITS-1:0]   w_alu_b_nxt;
    logic [OP_BITS-1:0]     w_alu_op_nxt;
    logic                   w_busy_nxt;
    logic                   w_err_drop_nxt;

    // A byte is usable only when it arrives cleanly while collecting operands;
    // anything else that shows up is dropped and flagged.
    assign w_accept   = rx_valid & ~rx_ferr;
    assign w_rx_phase = (r_state == S_A) || (r_state == S_B) || (r_state == S_OP);
    assign w_drop     = rx_valid & (rx_ferr | ~w_rx_phase);

`ifdef UART_ALU_IF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_run;

    assign w_tmo_run = ((r_state == S_B) || (r_state == S_OP)) && !rx_valid;
    assign w_timeout = w_tmo_run && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter between operand bytes; any byte or leaving the
    // collect states restarts it from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (w_tmo_run) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end
`else
    assign w_timeout = 1'b0;

    // TIMEOUT_CYCLES is only consumed when the timeout is built in.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: collect three bytes, latch, send, then track the
    // transmitter's busy pulse before accepting a new command.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_A: begin
                if (w_accept) w_state_nxt = S_B;
                else          w_state_nxt = S_A;
            end
            S_B: begin
                if (w_accept)       w_state_nxt = S_OP;
                else if (rx_valid)  w_state_nxt = S_A;
                else if (w_timeout) w_state_nxt = S_A;
                else                w_state_nxt = S_B;
            end
            S_OP: begin
                if (w_accept)       w_state_nxt = S_LATCH;
                else if (rx_valid)  w_state_nxt = S_A;
                else if (w_timeout) w_state_nxt = S_A;
                else                w_state_nxt = S_OP;
            end
            S_LATCH: w_state_nxt = S_SEND;
            S_SEND: begin
                if (!tx_busy) w_state_nxt = S_WAIT_HI;
                else          w_state_nxt = S_SEND;
            end
            S_WAIT_HI: begin
                if (tx_busy) w_state_nxt = S_WAIT_LO;
                else         w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_LO: begin
                if (!tx_busy) w_state_nxt = S_A;
                else          w_state_nxt = S_WAIT_LO;
            end
            default: w_state_nxt = S_A;
        endcase
    end

    // Next values of the registered outputs; everything holds unless the
    // current state owns that register.
    always_comb begin
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_alu_a_nxt    = r_alu_a;
        w_alu_b_nxt    = r_alu_b;
        w_alu_op_nxt   = r_alu_op;
        w_busy_nxt     = (w_state_nxt != S_A);
        w_err_drop_nxt = r_err_drop | w_drop;
        case (r_state)
            S_A: begin
                if (w_accept) w_alu_a_nxt = rx_data;
                else          w_alu_a_nxt = r_alu_a;
            end
            S_B: begin
                if (w_accept) w_alu_b_nxt = rx_data;
                else          w_alu_b_nxt = r_alu_b;
            end
            S_OP: begin
                if (w_accept) w_alu_op_nxt = rx_data[OP_BITS-1:0];
                else          w_alu_op_nxt = r_alu_op;
            end
            S_LATCH: w_tx_data_nxt = alu_result;
            S_SEND:  w_tx_start_nxt = ~tx_busy;
            default: w_tx_start_nxt = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= {DATA_BITS{1'b0}};
            r_alu_a    <= {DATA_BITS{1'b0}};
            r_alu_b    <= {DATA_BITS{1'b0}};
            r_alu_op   <= {OP_BITS{1'b0}};
            r_busy     <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_op   <= w_alu_op_nxt;
            r_busy     <= w_busy_nxt;
            r_err_drop <= w_err_drop_nxt;
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign busy     = r_busy;
    assign err_drop = r_err_drop;

endmodule

// File: tb/tb_uart_alu_if.sv
// Self-checking bench for uart_alu_if with a stub ALU and a byte-level
// reference model of the command protocol.
module tb_uart_alu_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ferr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       err_drop;

    int n_vec = 0;
    int n_bad = 0;
    int tx_count = 0;
    int m_err = 0;
    bit found;

    uart_alu_if #(.DATA_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ferr(rx_ferr), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    // Stub ALU: opcode bits [4:3] pick add/sub/xor/and.
    always_comb begin
        case (alu_op[4:3])
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a ^ alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end

    // Count transmit-request cycles away from the active edge.
    always @(negedge clk) if (tx_start === 1'b1) tx_count++;

    function automatic int ref_alu(int a, int b, int op);
        int sel;
        sel = (op % 64) / 8 % 4;
        if (sel == 0) return (a + b) % 256;
        else if (sel == 1) return (a - b + 256) % 256;
        else if (sel == 2) return a ^ b;
        else return a & b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int b, input bit ferr);
        rx_data = b[7:0];
        rx_valid = 1'b1;
        rx_ferr = ferr;
        step();
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
        tx_busy = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        m_err = 0;
    endtask

    // Wait (bounded) for tx_start, then play a short transmitter busy pulse.
    task automatic wait_tx(input string name);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s_tx_start_timeout: got no tx_start, expected one within 60 cycles", name);
        end
        tx_busy = 1'b1;
        step();
        step();
        step();
        tx_busy = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_vec++;
        if ({tx_start, tx_data, alu_a, alu_b, alu_op, busy, err_drop} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {tx_start, tx_data, alu_a, alu_b, alu_op, busy, err_drop});
        end
        step();
        rst = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b tx_start=%b, expected 0 0", busy, tx_start);
        end
    endtask

    task automatic test_basic();
        int c0;
        do_reset();
        c0 = tx_count;
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h20, 1'b0);
        n_vec++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20) begin
            n_bad++;
            $display("FAIL basic_operands: got a=%h b=%h op=%h, expected 05 03 20", alu_a, alu_b, alu_op);
        end
        step();
        n_vec++;
        if (tx_data !== 8'h08 || tx_start !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_latch: got tx_data=%h tx_start=%b, expected 08 0", tx_data, tx_start);
        end
        step();
        n_vec++;
        if (tx_start !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_tx_start_latency: got %b, expected 1", tx_start);
        end
        tx_busy = 1'b1;
        step();
        n_vec++;
        if (tx_start !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_tx_start_width: got %b, expected 0", tx_start);
        end
        step();
        tx_busy = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy_during_tx: got %b, expected 1", busy);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || tx_count - c0 !== 1) begin
            n_bad++;
            $display("FAIL basic_done: got busy=%b pulses=%0d, expected 0 1", busy, tx_count - c0);
        end
    endtask

    task automatic test_busy_hold();
        int c0;
        do_reset();
        c0 = tx_count;
        tx_busy = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h20, 1'b0);
        n_vec++;
        if (err_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_err_clean: got %b, expected 0", err_drop);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 7) send_byte(8'h55, 1'b0);
            else step();
        end
        n_vec++;
        if (tx_count != c0 || err_drop !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_no_start: got pulses=%0d err_drop=%b, expected 0 1", tx_count - c0, err_drop);
        end
        tx_busy = 1'b0;
        step();
        n_vec++;
        if (tx_start !== 1'b1 || tx_data !== 8'h33) begin
            n_bad++;
            $display("FAIL hold_release: got tx_start=%b tx_data=%h, expected 1 33", tx_start, tx_data);
        end
        tx_busy = 1'b1;
        step();
        send_byte(8'h66, 1'b0);
        tx_busy = 1'b0;
        step();
        step();
        n_vec++;
        if (tx_count - c0 !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_single_start: got pulses=%0d busy=%b, expected 1 0", tx_count - c0, busy);
        end
    endtask

    task automatic test_ferr();
        int c0;
        do_reset();
        c0 = tx_count;
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b1);
        n_vec++;
        if (err_drop !== 1'b1 || busy !== 1'b0 || alu_a !== 8'h05 || alu_b !== 8'h00) begin
            n_bad++;
            $display("FAIL ferr_discard: got err=%b busy=%b a=%h b=%h, expected 1 0 05 00",
                     err_drop, busy, alu_a, alu_b);
        end
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        wait_tx("ferr");
        n_vec++;
        if (tx_data !== 8'h00 || tx_count - c0 !== 1 || err_drop !== 1'b1) begin
            n_bad++;
            $display("FAIL ferr_wrap: got tx_data=%h pulses=%0d err=%b, expected 00 1 1",
                     tx_data, tx_count - c0, err_drop);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        do_reset();
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h20, 1'b0);
        step();
        step();
        tx_busy = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({tx_start, tx_data, alu_a, alu_b, alu_op, busy, err_drop} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h, expected 0",
                     {tx_start, tx_data, alu_a, alu_b, alu_op, busy, err_drop});
        end
        tx_busy = 1'b0;
        step();
        rst = 1'b1;
        step();
        c0 = tx_count;
        send_byte(8'h20, 1'b0);
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (tx_count != c0 || busy !== 1'b1 || alu_a !== 8'h20) begin
            n_bad++;
            $display("FAIL reset_mid_restart: got pulses=%0d busy=%b a=%h, expected 0 1 20",
                     tx_count - c0, busy, alu_a);
        end
    endtask

    task automatic test_random();
        int got[$];
        int b, c0, exp;
        bit ok;
        do_reset();
        for (int cmd = 0; cmd < 25; cmd++) begin
            c0 = tx_count;
            got.delete();
            while (got.size() < 3) begin
                b = $urandom_range(255);
                if ($urandom_range(7) == 0) begin
                    send_byte(b, 1'b1);
                    got.delete();
                    m_err = 1;
                end else begin
                    send_byte(b, 1'b0);
                    got.push_back(b);
                end
                if (got.size() < 3) repeat ($urandom_range(2)) step();
            end
            if ($urandom_range(4) == 0) begin
                send_byte($urandom_range(255), 1'($urandom_range(1)));
                m_err = 1;
            end
            exp = ref_alu(got[0], got[1], got[2]);
            wait_tx("random");
            ok = (tx_data === 8'(exp)) && (tx_count - c0 == 1) && (err_drop === 1'(m_err))
                 && (busy === 1'b0) && (alu_a === 8'(got[0])) && (alu_b === 8'(got[1]))
                 && (alu_op === 6'(got[2] % 64));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL random_cmd%0d: got data=%h pulses=%0d err=%b busy=%b a=%h b=%h op=%h, expected %h 1 %0d 0 %h %h %h",
                         cmd, tx_data, tx_count - c0, err_drop, busy, alu_a, alu_b, alu_op,
                         exp, m_err, got[0], got[1], got[2] % 64);
            end
        end
    endtask

    task automatic test_timeout();
        int c0;
        int exp_data;
        int exp_err;
`ifdef UART_ALU_IF_TIMEOUT_EN
        exp_data = 8'h09;
        exp_err  = 0;
`else
        exp_data = 8'h0C;
        exp_err  = 1;
`endif
        do_reset();
        c0 = tx_count;
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 101; i++) step();
        send_byte(8'h07, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        wait_tx("timeout");
        n_vec++;
        if (tx_data !== 8'(exp_data) || err_drop !== 1'(exp_err) || tx_count - c0 !== 1) begin
            n_bad++;
            $display("FAIL timeout_result: got data=%h err=%b pulses=%0d, expected %h %0d 1",
                     tx_data, err_drop, tx_count - c0, exp_data, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_hold();
        test_ferr();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
